// File: rtl/bcd_stopwatch_counter_if.sv
// Control/display bundle between the stopwatch and its neighbours:
// push-button levels in, four BCD digits and status flags out.
interface bcd_stopwatch_counter_if;
  localparam int unsigned DIGIT_W = 4;

  logic               start_stop;
  logic               clear;
  logic [DIGIT_W-1:0] digit0;
  logic [DIGIT_W-1:0] digit1;
  logic [DIGIT_W-1:0] digit2;
  logic [DIGIT_W-1:0] digit3;
  logic               running;
  logic               overflow;

  modport master (
    output start_stop, clear,
    input  digit0, digit1, digit2, digit3, running, overflow
  );

  modport slave (
    input  start_stop, clear,
    output digit0, digit1, digit2, digit3, running, overflow
  );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch (00.00..99.99): tick prescaler, button edge
// detection, run-control FSM and a cascaded, saturating BCD counter.
module bcd_stopwatch_counter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_stopwatch_counter_if.slave sw
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = $clog2(DIV);
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NDIG    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic                             ss_q, clr_q;
  logic [PRESC_W-1:0]               presc_q, presc_d;
  logic [NDIG-1:0][DIGIT_W-1:0]     digits_q, digits_d;
  logic                             running_q, running_d;
  logic                             overflow_q, overflow_d;

  logic                             ss_rise, clr_rise;
  logic                             tick;
  logic                             all_nines;
  logic                             inc_en;
  logic [NDIG-1:0]                  is_nine;
  logic [NDIG-1:0]                  carry;

  assign ss_rise  = sw.start_stop & ~ss_q;
  assign clr_rise = sw.clear & ~clr_q;
  assign tick     = (state_q == S_RUN) && (presc_q == PRESC_W'(DIV - 1));

  // Prescaler only advances in RUN, so a pause keeps the partial period.
  always_comb begin
    presc_d = presc_q;
    if (clr_rise) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  assign all_nines = &is_nine;
  assign inc_en    = tick & ~all_nines;

  // Carry into each digit is computed directly from the lower digits, so a
  // full ripple such as 09.99 -> 10.00 settles within one cycle.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    assign is_nine[g] = (digits_q[g] == DIGIT_W'(9));
    if (g == 0) begin : g_lsd
      assign carry[g] = inc_en;
    end else begin : g_upper
      assign carry[g] = inc_en & (&is_nine[g-1:0]);
    end
    assign digits_d[g] = clr_rise  ? '0 :
                         !carry[g] ? digits_q[g] :
                         is_nine[g] ? '0 : digits_q[g] + DIGIT_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a saturating tick wins over a simultaneous pause.
  always_comb begin
    state_d = state_q;
    if (clr_rise) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (ss_rise) state_d = S_RUN;
        S_RUN: begin
          if (tick && all_nines) begin
            state_d = S_DONE;
          end else if (ss_rise) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: if (ss_rise) state_d = S_RUN;
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Status flags follow the next state so they change on the same edge.
  always_comb begin
    running_d  = 1'b0;
    overflow_d = 1'b0;
    unique case (state_d)
      S_RUN:   running_d  = 1'b1;
      S_DONE:  overflow_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_q       <= 1'b0;
      clr_q      <= 1'b0;
      presc_q    <= '0;
      digits_q   <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ss_q       <= sw.start_stop;
      clr_q      <= sw.clear;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign sw.digit0   = digits_q[0];
  assign sw.digit1   = digits_q[1];
  assign sw.digit2   = digits_q[2];
  assign sw.digit3   = digits_q[3];
  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;

endmodule
